// File: rtl/vec_sweep_capture.sv
// rtl/vec_sweep_capture.sv - exhaustive input sweep with settle delay and buffered response capture
//
// Drives every vector 0..2^N_W-1 onto a device under observation, holds each one
// for SETTLE cycles, then samples the response into a DEPTH-entry show-ahead FIFO
// that a reader drains through rd_valid/rd_ready.
//
// Optional build macro: SWEEP_MISR_EN adds the misr_sig response signature output.
//
// Ports:
//   CK        in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   begin a sweep (honoured in IDLE or DONE only)
//   dut_resp  in   [O_W]  observed response
//   vec_out   out  [N_W]  vector currently applied
//   busy      out  high while settling or capturing
//   done      out  high once the last vector has been captured
//   rd_valid  out  FIFO head is valid
//   rd_vec    out  [N_W]  vector field of FIFO head
//   rd_resp   out  [O_W]  response field of FIFO head
//   rd_ready  in   reader accepts the head
//   misr_sig  out  [O_W]  signature over captured responses (SWEEP_MISR_EN only)

module vec_sweep_capture #(
  parameter int N_W    = 1,
  parameter int O_W    = 1,
  parameter int SETTLE = 1,
  parameter int DEPTH  = 4
) (
  input  logic           CK,
  input  logic           reset,
  input  logic           start,
  input  logic [O_W-1:0] dut_resp,
  output logic [N_W-1:0] vec_out,
  output logic           busy,
  output logic           done,
  output logic           rd_valid,
  output logic [N_W-1:0] rd_vec,
  output logic [O_W-1:0] rd_resp,
  input  logic           rd_ready
`ifdef SWEEP_MISR_EN
  ,
  output logic [O_W-1:0] misr_sig
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int EW = N_W + O_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  cnt_q;
  logic [N_W-1:0] vec_q;
  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           push, pop, accept_start, last_vec, settle_end;

  assign last_vec     = (vec_q == {N_W{1'b1}});
  assign settle_end   = (cnt_q == SW'(SETTLE - 1));
  assign accept_start = start && (state_q == S_IDLE || state_q == S_DONE);
  assign rd_valid     = (count != '0);
  assign pop          = rd_valid && rd_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push         = (state_q == S_CAPTURE) && ((count != CW'(DEPTH)) || pop);

  assign vec_out = vec_q;
  assign busy    = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  assign done    = (state_q == S_DONE);
  assign rd_vec  = mem[rd_ptr][EW-1:O_W];
  assign rd_resp = mem[rd_ptr][O_W-1:0];

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start)      state_d = S_SETTLE;
      S_SETTLE:       if (settle_end) state_d = S_CAPTURE;
      S_CAPTURE:      if (push)       state_d = last_vec ? S_DONE : S_SETTLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Vector and settle counter
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else if (accept_start) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_SETTLE) begin
      cnt_q <= cnt_q + SW'(1);
    end else if (push && !last_vec) begin
      vec_q <= vec_q + N_W'(1);
      cnt_q <= '0;
    end
  end

  // Capture FIFO; storage needs no reset because count gates visibility.
  always_ff @(posedge CK) begin
    if (push) mem[wr_ptr] <= {vec_q, dut_resp};
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SWEEP_MISR_EN
  logic [O_W-1:0] misr_rot;

  generate
    if (O_W == 1) begin : g_rot1
      assign misr_rot = misr_sig;
    end else begin : g_rotn
      assign misr_rot = {misr_sig[O_W-2:0], misr_sig[O_W-1]};
    end
  endgenerate

  always_ff @(posedge CK or negedge reset) begin
    if (!reset)            misr_sig <= '0;
    else if (accept_start) misr_sig <= '0;
    else if (push)         misr_sig <= misr_rot ^ dut_resp;
  end
`endif

endmodule
